// File: rtl/vx_tl_dmem_adapter.sv
// vx_tl_dmem_adapter: registered bridge between the Vortex dcache core
// interface and NUM_LANES independent TileLink-UL lane ports.
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   dcache_req_*          : N-lane dcache request (shared tag), per-lane ready
//   dcache_rsp_*          : coalesced single-tag response with lane tmask
//   tl_a_*                : per-lane TL-UL A channel (Get/PutFull/PutPartial)
//   tl_d_*                : per-lane TL-UL D channel (AccessAck/AccessAckData)
//   idle                  : no outstanding requests and no buffered responses
//
// Optional feature macro VX_TL_ADAPTER_PERF_EN adds perf_reqs, perf_rsps and
// perf_stalls 32-bit wrapping counters.

module vx_tl_dmem_adapter #(
   parameter int unsigned NUM_LANES       = 4,
   parameter int unsigned WORD_ADDR_WIDTH = 30,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned TAG_WIDTH       = 10,
   parameter int unsigned SOURCE_WIDTH    = 10,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [NUM_LANES-1:0]                    dcache_req_valid,
   input  logic [NUM_LANES-1:0]                    dcache_req_rw,
   input  logic [NUM_LANES*DATA_WIDTH/8-1:0]       dcache_req_byteen,
   input  logic [NUM_LANES*WORD_ADDR_WIDTH-1:0]    dcache_req_addr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]         dcache_req_data,
   input  logic [TAG_WIDTH-1:0]                    dcache_req_tag,
   output logic [NUM_LANES-1:0]                    dcache_req_ready,
   output logic                                    dcache_rsp_valid,
   output logic [NUM_LANES-1:0]                    dcache_rsp_tmask,
   output logic [NUM_LANES*DATA_WIDTH-1:0]         dcache_rsp_data,
   output logic [TAG_WIDTH-1:0]                    dcache_rsp_tag,
   input  logic                                    dcache_rsp_ready,
   output logic [NUM_LANES-1:0]                    tl_a_valid,
   input  logic [NUM_LANES-1:0]                    tl_a_ready,
   output logic [NUM_LANES*3-1:0]                  tl_a_opcode,
   output logic [NUM_LANES*4-1:0]                  tl_a_size,
   output logic [NUM_LANES*SOURCE_WIDTH-1:0]       tl_a_source,
   output logic [NUM_LANES*(WORD_ADDR_WIDTH+2)-1:0] tl_a_address,
   output logic [NUM_LANES*DATA_WIDTH/8-1:0]       tl_a_mask,
   output logic [NUM_LANES*DATA_WIDTH-1:0]         tl_a_data,
   input  logic [NUM_LANES-1:0]                    tl_d_valid,
   output logic [NUM_LANES-1:0]                    tl_d_ready,
   input  logic [NUM_LANES*3-1:0]                  tl_d_opcode,
   input  logic [NUM_LANES*SOURCE_WIDTH-1:0]       tl_d_source,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]         tl_d_data,
`ifdef VX_TL_ADAPTER_PERF_EN
   output logic [31:0]                             perf_reqs,
   output logic [31:0]                             perf_rsps,
   output logic [31:0]                             perf_stalls,
`endif
   output logic                                    idle
);

   localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ADDR_WIDTH = WORD_ADDR_WIDTH + 2;
   localparam int unsigned CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_ACK_DATA    = 3'd1;

   logic [CNT_WIDTH-1:0]  r_cnt  [NUM_LANES];
   logic [NUM_LANES-1:0]  r_occ;
   logic [TAG_WIDTH-1:0]  r_tag  [NUM_LANES];
   logic [DATA_WIDTH-1:0] r_data [NUM_LANES];

   logic [NUM_LANES-1:0]  w_not_max;
   logic [NUM_LANES-1:0]  w_a_fire;
   logic [NUM_LANES-1:0]  w_d_fire;
   logic [NUM_LANES-1:0]  w_load;
   logic [NUM_LANES-1:0]  w_pop;
   logic [NUM_LANES-1:0]  w_tmask;
   logic [TAG_WIDTH-1:0]  w_sel_tag;
   logic                  w_rsp_fire;
   logic                  w_unused_src;

   // Upper source bits beyond the tag are not part of the response tag.
   assign w_unused_src = ^tl_d_source;

   // Request path: issue gated by per-lane outstanding limit.
   always_comb begin
      w_not_max        = '0;
      w_a_fire         = '0;
      tl_a_valid       = '0;
      dcache_req_ready = '0;
      tl_a_opcode      = '0;
      tl_a_size        = '0;
      tl_a_source      = '0;
      tl_a_address     = '0;
      tl_a_mask        = '0;
      tl_a_data        = dcache_req_data;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_not_max[i]        = (r_cnt[i] != CNT_WIDTH'(MAX_OUTSTANDING));
         tl_a_valid[i]       = dcache_req_valid[i] && w_not_max[i];
         dcache_req_ready[i] = tl_a_ready[i] && w_not_max[i];
         w_a_fire[i]         = tl_a_valid[i] && tl_a_ready[i];
         tl_a_size[i*4 +: 4] = 4'd2;
         tl_a_source[i*SOURCE_WIDTH +: SOURCE_WIDTH] = SOURCE_WIDTH'(dcache_req_tag);
         tl_a_address[i*ADDR_WIDTH +: ADDR_WIDTH] =
            {dcache_req_addr[i*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH], 2'b00};
         if (!dcache_req_rw[i]) begin
            tl_a_opcode[i*3 +: 3]              = OP_GET;
            tl_a_mask[i*MASK_WIDTH +: MASK_WIDTH] = '1;
         end else begin
            tl_a_mask[i*MASK_WIDTH +: MASK_WIDTH] = dcache_req_byteen[i*MASK_WIDTH +: MASK_WIDTH];
            if (&dcache_req_byteen[i*MASK_WIDTH +: MASK_WIDTH])
               tl_a_opcode[i*3 +: 3] = OP_PUT_FULL;
            else
               tl_a_opcode[i*3 +: 3] = OP_PUT_PARTIAL;
         end
      end
   end

   // Coalescing: respond with the tag of the lowest occupied lane.
   always_comb begin
      w_sel_tag = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (r_occ[i]) w_sel_tag = r_tag[i];
      end
      w_tmask         = '0;
      dcache_rsp_data = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_tmask[i] = r_occ[i] && (r_tag[i] == w_sel_tag);
         if (w_tmask[i]) dcache_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
      end
      dcache_rsp_valid = |r_occ;
      dcache_rsp_tmask = w_tmask;
      dcache_rsp_tag   = w_sel_tag;
      w_rsp_fire       = dcache_rsp_valid && dcache_rsp_ready;
      w_pop            = w_rsp_fire ? w_tmask : '0;
      // A popping entry frees its slot for a same-cycle reload.
      tl_d_ready       = ~r_occ | w_pop;
      w_d_fire         = tl_d_valid & tl_d_ready;
      w_load           = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_load[i] = w_d_fire[i] && (tl_d_opcode[i*3 +: 3] == OP_ACK_DATA);
      end
   end

   // Idle derives from registered state only.
   always_comb begin
      idle = ~|r_occ;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (r_cnt[i] != '0) idle = 1'b0;
      end
   end

   // Outstanding counters and response buffer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_occ <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            r_cnt[i]  <= '0;
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_occ <= w_load | (r_occ & ~w_pop);
         for (int i = 0; i < NUM_LANES; i++) begin
            if (w_a_fire[i] && !w_d_fire[i])
               r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            else if (!w_a_fire[i] && w_d_fire[i])
               r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
            if (w_load[i]) begin
               r_tag[i]  <= tl_d_source[i*SOURCE_WIDTH +: TAG_WIDTH];
               r_data[i] <= tl_d_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

`ifdef VX_TL_ADAPTER_PERF_EN
   logic [31:0] r_perf_reqs;
   logic [31:0] r_perf_rsps;
   logic [31:0] r_perf_stalls;
   logic [31:0] w_req_cnt;

   always_comb begin
      w_req_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_req_cnt = w_req_cnt + 32'(w_a_fire[i]);
      end
   end

   // Performance counters, wrapping at 2^32.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_perf_reqs   <= '0;
         r_perf_rsps   <= '0;
         r_perf_stalls <= '0;
      end else begin
         r_perf_reqs <= r_perf_reqs + w_req_cnt;
         if (w_rsp_fire) r_perf_rsps <= r_perf_rsps + 32'd1;
         if (|(dcache_req_valid & ~dcache_req_ready)) r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign perf_reqs   = r_perf_reqs;
   assign perf_rsps   = r_perf_rsps;
   assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_tl_dmem_adapter.sv
// Testbench for vx_tl_dmem_adapter (4 lanes, MAX_OUTSTANDING=2): table of
// request-path vectors plus hand-written multi-cycle sequences.

module tb_vx_tl_dmem_adapter;

   logic          clock = 1'b0;
   logic          reset;
   logic [3:0]    req_valid, req_rw, req_ready;
   logic [15:0]   req_byteen;
   logic [119:0]  req_addr;
   logic [127:0]  req_data;
   logic [9:0]    req_tag;
   logic          rsp_valid, rsp_ready;
   logic [3:0]    rsp_tmask;
   logic [127:0]  rsp_data;
   logic [9:0]    rsp_tag;
   logic [3:0]    a_valid, a_ready, d_valid, d_ready;
   logic [11:0]   a_opcode, d_opcode;
   logic [15:0]   a_size, a_mask;
   logic [39:0]   a_source, d_source;
   logic [127:0]  a_address, a_data, d_data;
   logic          idle;

   int tests = 0;
   int fails = 0;

   vx_tl_dmem_adapter #(
      .NUM_LANES(4), .WORD_ADDR_WIDTH(30), .DATA_WIDTH(32),
      .TAG_WIDTH(10), .SOURCE_WIDTH(10), .MAX_OUTSTANDING(2)
   ) dut (
      .clock(clock), .reset(reset),
      .dcache_req_valid(req_valid), .dcache_req_rw(req_rw),
      .dcache_req_byteen(req_byteen), .dcache_req_addr(req_addr),
      .dcache_req_data(req_data), .dcache_req_tag(req_tag),
      .dcache_req_ready(req_ready),
      .dcache_rsp_valid(rsp_valid), .dcache_rsp_tmask(rsp_tmask),
      .dcache_rsp_data(rsp_data), .dcache_rsp_tag(rsp_tag),
      .dcache_rsp_ready(rsp_ready),
      .tl_a_valid(a_valid), .tl_a_ready(a_ready), .tl_a_opcode(a_opcode),
      .tl_a_size(a_size), .tl_a_source(a_source), .tl_a_address(a_address),
      .tl_a_mask(a_mask), .tl_a_data(a_data),
      .tl_d_valid(d_valid), .tl_d_ready(d_ready), .tl_d_opcode(d_opcode),
      .tl_d_source(d_source), .tl_d_data(d_data),
      .idle(idle)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          lane;
      logic        rw;
      logic [3:0]  be;
      logic [29:0] addr;
      logic [31:0] data;
      logic [9:0]  tag;
      logic        a_rdy;
      logic [2:0]  e_op;
      logic [3:0]  e_mask;
      logic [31:0] e_addr;
      logic [9:0]  e_src;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clean();
      req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0;
      req_data = '0; req_tag = '0; a_ready = 4'hF; rsp_ready = 1'b0;
      d_valid = '0; d_opcode = '0; d_source = '0; d_data = '0;
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(0));
      chk({tag, ".tmask"},     128'(rsp_tmask), 128'(0));
      chk({tag, ".rsp_tag"},   128'(rsp_tag),   128'(0));
      chk({tag, ".rsp_data"},  rsp_data,        128'(0));
      chk({tag, ".d_ready"},   128'(d_ready),   128'hF);
      chk({tag, ".idle"},      128'(idle),      128'(1));
      chk({tag, ".req_ready"}, 128'(req_ready), 128'hF);
   endtask

   initial begin
      vecs[0] = '{0, 1'b0, 4'b0000, 30'h100,      32'h0,        10'h005, 1'b1, 3'd4, 4'hF, 32'h400,      10'h005, 1'b1};
      vecs[1] = '{1, 1'b1, 4'b1111, 30'h3FFFFFFF, 32'hA5A5A5A5, 10'h3FF, 1'b1, 3'd0, 4'hF, 32'hFFFFFFFC, 10'h3FF, 1'b1};
      vecs[2] = '{2, 1'b1, 4'b0011, 30'h102,      32'h12345678, 10'h001, 1'b0, 3'd1, 4'h3, 32'h408,      10'h001, 1'b0};
      vecs[3] = '{3, 1'b1, 4'b0000, 30'h7,        32'h0BADF00D, 10'h2AA, 1'b1, 3'd1, 4'h0, 32'h1C,       10'h2AA, 1'b1};
      vecs[4] = '{0, 1'b0, 4'b0101, 30'h2000,     32'hFFFFFFFF, 10'h100, 1'b0, 3'd4, 4'hF, 32'h8000,     10'h100, 1'b0};
      vecs[5] = '{3, 1'b1, 4'b1000, 30'h55,       32'h87654321, 10'h03C, 1'b1, 3'd1, 4'h8, 32'h154,      10'h03C, 1'b1};

      clean();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      chk_reset_state("reset");

      // Request-path table: inputs applied and withdrawn between edges.
      foreach (vecs[k]) begin
         step();
         clean();
         req_valid[vecs[k].lane]             = 1'b1;
         req_rw[vecs[k].lane]                = vecs[k].rw;
         req_byteen[vecs[k].lane*4 +: 4]     = vecs[k].be;
         req_addr[vecs[k].lane*30 +: 30]     = vecs[k].addr;
         req_data[vecs[k].lane*32 +: 32]     = vecs[k].data;
         req_tag                             = vecs[k].tag;
         a_ready[vecs[k].lane]               = vecs[k].a_rdy;
         #1;
         chk($sformatf("vec%0d.opcode", k), 128'(a_opcode[vecs[k].lane*3 +: 3]), 128'(vecs[k].e_op));
         chk($sformatf("vec%0d.mask", k),   128'(a_mask[vecs[k].lane*4 +: 4]), 128'(vecs[k].e_mask));
         chk($sformatf("vec%0d.addr", k),   128'(a_address[vecs[k].lane*32 +: 32]), 128'(vecs[k].e_addr));
         chk($sformatf("vec%0d.source", k), 128'(a_source[vecs[k].lane*10 +: 10]), 128'(vecs[k].e_src));
         chk($sformatf("vec%0d.size", k),   128'(a_size[vecs[k].lane*4 +: 4]), 128'(2));
         chk($sformatf("vec%0d.data", k),   128'(a_data[vecs[k].lane*32 +: 32]), 128'(vecs[k].data));
         chk($sformatf("vec%0d.a_valid", k), 128'(a_valid), 128'(4'b0001 << vecs[k].lane));
         chk($sformatf("vec%0d.req_ready", k), 128'(req_ready[vecs[k].lane]), 128'(vecs[k].e_rdy));
         clean();
      end

      // Four-lane Get, all lanes answer in the same cycle.
      step();
      req_valid = 4'hF; req_tag = 10'h005;
      req_addr = {30'h103, 30'h102, 30'h101, 30'h100};
      #1;
      chk("s1.address", a_address, {32'h40C, 32'h408, 32'h404, 32'h400});
      chk("s1.opcode",  128'(a_opcode), 128'h924);
      chk("s1.size",    128'(a_size), 128'h2222);
      chk("s1.source",  128'(a_source), 128'({10'h5, 10'h5, 10'h5, 10'h5}));
      chk("s1.a_valid", 128'(a_valid), 128'hF);
      step();
      clean();
      #1;
      chk("s1.busy", 128'(idle), 128'(0));
      d_valid = 4'hF; d_opcode = {4{3'd1}}; d_source = {4{10'h005}};
      d_data = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
      #1;
      chk("s1.d_ready", 128'(d_ready), 128'hF);
      step();
      d_valid = '0;
      #1;
      chk("s1.rsp_valid", 128'(rsp_valid), 128'(1));
      chk("s1.tmask", 128'(rsp_tmask), 128'hF);
      chk("s1.tag", 128'(rsp_tag), 128'h5);
      chk("s1.data", rsp_data, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});
      step();
      chk("s1.hold_tag", 128'(rsp_tag), 128'h5);
      chk("s1.hold_tmask", 128'(rsp_tmask), 128'hF);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      #1;
      chk("s1.drained", 128'(rsp_valid), 128'(0));
      chk("s1.idle", 128'(idle), 128'(1));

      // Partial write acknowledged with AccessAck.
      step();
      req_valid = 4'b0001; req_rw = 4'b0001; req_byteen = 16'h0003;
      req_addr[29:0] = 30'h200; req_data[31:0] = 32'h0000BEEF; req_tag = 10'h001;
      #1;
      chk("s2.opcode", 128'(a_opcode[2:0]), 128'(1));
      chk("s2.mask", 128'(a_mask[3:0]), 128'h3);
      step();
      clean();
      #1;
      chk("s2.busy", 128'(idle), 128'(0));
      d_valid = 4'b0001; d_opcode = '0; d_source[9:0] = 10'h001;
      #1;
      chk("s2.d_ready", 128'(d_ready[0]), 128'(1));
      step();
      d_valid = '0;
      #1;
      chk("s2.no_rsp", 128'(rsp_valid), 128'(0));
      chk("s2.idle", 128'(idle), 128'(1));

      // Mixed tags coalesced lowest-lane first.
      step();
      req_valid = 4'b0111; req_tag = 10'h003;
      step();
      clean();
      rsp_ready = 1'b1;
      d_valid = 4'b0111; d_opcode = {4{3'd1}};
      d_source = {10'h0, 10'h003, 10'h007, 10'h003};
      d_data = {32'h0, 32'h33333333, 32'h22222222, 32'h11111111};
      step();
      d_valid = '0;
      #1;
      chk("s3.tag_a", 128'(rsp_tag), 128'h3);
      chk("s3.tmask_a", 128'(rsp_tmask), 128'h5);
      chk("s3.data_a", rsp_data, {32'h0, 32'h33333333, 32'h0, 32'h11111111});
      step();
      chk("s3.tag_b", 128'(rsp_tag), 128'h7);
      chk("s3.tmask_b", 128'(rsp_tmask), 128'h2);
      chk("s3.data_b", rsp_data, {32'h0, 32'h0, 32'h22222222, 32'h0});
      step();
      chk("s3.empty", 128'(rsp_valid), 128'(0));
      chk("s3.idle", 128'(idle), 128'(1));

      // Backpressure: occupied entry blocks D, then pops and reloads together.
      clean();
      req_valid = 4'b0001;
      step(); step();
      clean();
      #1;
      chk("s5.limit", 128'(req_ready[0]), 128'(0));
      d_valid = 4'b0001; d_opcode = {4{3'd1}}; d_source[9:0] = 10'h009; d_data[31:0] = 32'hDEADBEEF;
      step();
      d_source[9:0] = 10'h00A; d_data[31:0] = 32'hCAFEF00D;
      #1;
      chk("s5.d_blocked", 128'(d_ready[0]), 128'(0));
      chk("s5.tag", 128'(rsp_tag), 128'h9);
      chk("s5.data", rsp_data, 128'h0DEADBEEF);
      step();
      chk("s5.hold_tag", 128'(rsp_tag), 128'h9);
      chk("s5.hold_data", rsp_data, 128'h0DEADBEEF);
      chk("s5.hold_d_ready", 128'(d_ready[0]), 128'(0));
      rsp_ready = 1'b1;
      #1;
      chk("s5.pop_ready", 128'(d_ready[0]), 128'(1));
      step();
      d_valid = '0; rsp_ready = 1'b0;
      #1;
      chk("s5.reload_valid", 128'(rsp_valid), 128'(1));
      chk("s5.reload_tag", 128'(rsp_tag), 128'hA);
      chk("s5.reload_data", rsp_data, 128'h0CAFEF00D);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("s5.idle", 128'(idle), 128'(1));

      // Outstanding limit, release, then asynchronous reset mid-sequence.
      clean();
      req_valid = 4'b0010;
      step(); step();
      #1;
      chk("s4.req_ready_max", 128'(req_ready[1]), 128'(0));
      chk("s4.a_valid_max", 128'(a_valid[1]), 128'(0));
      d_valid = 4'b0010; d_opcode = {4{3'd1}}; d_data[63:32] = 32'h00000055;
      #1;
      chk("s4.d_ready", 128'(d_ready[1]), 128'(1));
      step();
      d_valid = '0;
      #1;
      chk("s4.req_ready_back", 128'(req_ready[1]), 128'(1));
      chk("s4.a_valid_back", 128'(a_valid[1]), 128'(1));
      chk("s4.tmask", 128'(rsp_tmask), 128'h2);
      req_valid = '0;
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("s6");
      step();
      reset = 1'b0;
      clean();
      step();
      chk("s6.idle_after", 128'(idle), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
